swd_frame_ctl: RTL

//  Sequencer between the SWD byte-capture stage and the UART transmitter. It buffers

---
 rtl/swd_frame_pkg.sv | 16 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/swd_frame_ctl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/swd_frame_pkg.sv
// Shared types and defaults for the SWD capture-to-UART frame sequencer.
package swd_frame_pkg;

  // Frame sequencer states; IDLE must stay at zero so a cleared register is idle.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } frame_state_t;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through head and occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write; contents are only ever read behind a valid count.
  // NOTE: the data array has no reset -- occupancy lives in count/pointers, and
  // leaving the RAM unreset lets it map onto plain memory cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  // NOTE: sequential state uses <= so every flop samples pre-edge values and
  // the order of statements inside the block cannot change the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/swd_frame_ctl.sv
// Buffers captured SWD bytes and emits them to the UART TX as frames:
// SYNC, LEN, payload, XOR checksum. A frame closes on a full payload, an idle
// timeout, or a synchronised SWD line reset.
module swd_frame_ctl
  import swd_frame_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 16,
  parameter int         MAX_PAYLOAD  = 8,
  parameter int         IDLE_TIMEOUT = 1024,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] cap_data,
  input  logic       cap_rdy,
  input  logic       swdrst,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       overflow,
  output logic [7:0] frame_cnt,
  output logic       busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TIMER_MAX = TW'(IDLE_TIMEOUT);

  frame_state_t  state;
  logic [7:0]    len;
  logic [7:0]    remaining;
  logic [7:0]    csum;
  logic [TW-1:0] timer;
  logic          swd_s1, swd_s2, swd_s3;
  logic          pend_rst;

  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          handshake;
  logic          pop;
  logic          push_req;
  logic          push_acc;
  logic          has_data;
  logic          start_full;
  logic          start_tmo;
  logic          start;
  logic          rst_caused;
  logic [7:0]    len_next;

  assign handshake  = tx_valid & tx_ready;
  assign pop        = (state == ST_DATA) & handshake;
  assign push_req   = cap_rdy & enable;
  assign push_acc   = push_req & (~fifo_full | pop);
  assign has_data   = ~fifo_empty;
  // Start causes in priority order: full payload, idle timeout, line reset.
  assign start_full = (fifo_count >= MAX_CNT);
  assign start_tmo  = has_data & (timer == TIMER_MAX);
  assign start      = (state == ST_IDLE) & (start_full | start_tmo | (has_data & pend_rst));
  assign rst_caused = start & ~start_full & ~start_tmo;
  assign len_next   = start_full ? 8'(MAX_PAYLOAD) : 8'(fifo_count);

  assign tx_valid = (state != ST_IDLE);
  assign busy     = (state != ST_IDLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .wdata (cap_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output byte selection by frame phase; zero whenever no frame is active.
  // NOTE: the default assignment first keeps this purely combinational; a path
  // that left tx_data unassigned would infer a latch.
  always_comb begin
    tx_data = 8'h00;
    case (state)
      ST_SYNC: tx_data = SYNC_BYTE;
      ST_LEN:  tx_data = len;
      ST_DATA: tx_data = fifo_head;
      ST_CSUM: tx_data = csum;
      default: tx_data = 8'h00;
    endcase
  end

  // Frame sequencer: latch length at start, walk SYNC/LEN/DATA/CSUM on handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      len       <= 8'h00;
      remaining <= 8'h00;
      csum      <= 8'h00;
      frame_cnt <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          len       <= len_next;
          remaining <= len_next;
          csum      <= 8'h00;
          state     <= ST_SYNC;
        end
        ST_SYNC: if (handshake) state <= ST_LEN;
        ST_LEN:  if (handshake) state <= ST_DATA;
        ST_DATA: if (handshake) begin
          csum      <= csum ^ fifo_head;
          remaining <= remaining - 8'd1;
          if (remaining == 8'd1) state <= ST_CSUM;
        end
        ST_CSUM: if (handshake) begin
          frame_cnt <= frame_cnt + 8'd1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Idle timer: restarts on every stored byte, counts up while bytes wait.
  always_ff @(posedge clk) begin
    if (reset)                                 timer <= '0;
    else if (push_acc)                         timer <= '0;
    else if (has_data && timer != TIMER_MAX)   timer <= timer + TW'(1);
  end

  // Sticky overflow: a captured byte found the FIFO full with no pop to make room.
  always_ff @(posedge clk) begin
    if (reset)                                   overflow <= 1'b0;
    else if (push_req && fifo_full && !pop)      overflow <= 1'b1;
  end

  // Two-flop synchroniser for the raw SWDRST pin plus a delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      swd_s1 <= 1'b0;
      swd_s2 <= 1'b0;
      swd_s3 <= 1'b0;
    end else begin
      swd_s1 <= swdrst;
      swd_s2 <= swd_s1;
      swd_s3 <= swd_s2;
    end
  end

  // Pending line reset: set on a synchronised rising edge (wins over a same-cycle
  // clear), cleared when the frame it caused starts.
  always_ff @(posedge clk) begin
    if (reset)                    pend_rst <= 1'b0;
    else if (swd_s2 && !swd_s3)   pend_rst <= 1'b1;
    else if (rst_caused)          pend_rst <= 1'b0;
  end

endmodule
